ins_mem_loader: RTL and testbench
=================================

Name: ins_mem_loader

Overview:
- Writer side of the instruction-memory port: accepts a stream of 12-bit instruction words over a valid/ready handshake and writes them sequentially into Ins_Memory (address/data/wren), which the control unit otherwise only reads.
- Holds the processor in reset during a load, then releases it and issues a one-cycle start pulse so execution begins at PC 0.
- Sits between the host/bench stimulus and the Full_System top level.
- Drives the Ins_Memory write port and the CPU reset/start inputs.

Parameters:
- reg_width, 12, instruction/data word width
- Im_width, 8, instruction memory address width (depth 2^Im_width)

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset
- load_req  input  1  pulse: begin a load of load_len words; sampled only in IDLE
- load_len  input  Im_width+1  number of words to load, 0..2^Im_width; values above 2^Im_width are clamped to 2^Im_width
- in_valid  input  1  in_data holds a valid word
- in_data  input  reg_width  instruction word
- in_ready  output  1  loader accepts a word this cycle
- im_address  output  Im_width  Ins_Memory write address
- im_data  output  reg_width  Ins_Memory write data
- im_wren  output  1  Ins_Memory write enable
- cpu_reset  output  1  active-high reset to processor
- cpu_start  output  1  one-cycle start pulse to control unit
- busy  output  1  load in progress (state not IDLE)
- done  output  1  sticky: last load completed and CPU started
- checksum  output  reg_width  mod-2^reg_width sum of words accepted in current/last load

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, word counter=0, im_address=0, im_data=0, im_wren=0, in_ready=0.
  - cpu_reset=1, cpu_start=0, busy=0, done=0, checksum=0.
  - Reset mid-load aborts immediately; memory words already written are not cleared; CPU stays in reset until a later load completes.
- Outputs:
  - All outputs are registered except in_ready = (state==LOAD) and busy = (state!=IDLE). Both are decoded from the state register only, never from in_valid.
- States:
  - IDLE:
    - On load_req with load_len!=0: latch length, counter=0, checksum=0, done=0, cpu_reset=1; go to LOAD.
    - On load_req with load_len==0: done=0; go to RELEASE. No writes; the existing program is rerun.
  - LOAD:
    - A transfer occurs when in_valid & in_ready.
    - On each transfer, next cycle: im_address=counter[Im_width-1:0], im_data=in_data, im_wren=1, checksum+=in_data, counter+=1.
    - im_wren=0 in any cycle following a non-transfer cycle.
    - When the transfer is word number length (counter==length-1), go to FLUSH.
    - Exactly length words are accepted.
    - A full 256-word load writes addresses 0..255; the counter does not wrap before exit.
  - FLUSH: the last im_wren=1 cycle. in_ready=0. Next state RELEASE.
  - RELEASE: im_wren=0, cpu_reset=0. Next state START.
  - START: cpu_start=1 for exactly this cycle. Next state IDLE with done=1.
- Latency:
  - Write strobe occurs 1 cycle after the handshake.
  - cpu_reset falls 2 cycles after the last handshake.
  - cpu_start is 1 cycle after cpu_reset falls.
- Boundary conditions:
  - load_req while busy is ignored.
  - in_valid outside LOAD is ignored; no write, no checksum change.
  - in_data is don't-care when in_valid=0.
  - Back-to-back valid words give a full throughput of 1 word/cycle.

Decomposition:
- Shared package: state encoding (IDLE, LOAD, FLUSH, RELEASE, START as 3-bit localparams) and the default widths reg_width=12 and Im_width=8, shared with Full_System.
- No sub-module: a single FSM, counter and checksum register.

Test Plan:
- Reset held low for 2 cycles, then released -> cpu_reset=1, im_wren=0, busy=0, done=0, in_ready=0.
- load_req, load_len=3, words 12'h101,12'h202,12'h303 on consecutive cycles -> im_wren high 3 cycles writing addr 0/1/2 with those data; checksum=12'h606; cpu_reset falls 2 cycles after the 3rd handshake; cpu_start is a single-cycle pulse the next cycle; done=1.
- load_len=4 with in_valid toggling 1,0,1,0,1,0,1 -> exactly 4 writes, addresses 0..3 contiguous, im_wren low in gap cycles, in_ready drops after the 4th handshake.
- load_len=256, continuous words equal to their address -> last write at addr 8'hFF with data 12'h0FF; checksum=12'h7F80 mod 4096=12'hF80; no write to addr 0 after wrap.
- load_len=0 -> no im_wren, cpu_reset=0 then cpu_start pulse on following cycle, done=1.
- reset driven low after 2 of 5 words -> next cycle state IDLE, cpu_reset=1, busy=0, im_wren=0; second load_req while busy during a later load has no effect on length or counter.

Source files
------------

// File: rtl/ins_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the Full_System top level.
package ins_mem_loader_pkg;

    localparam int unsigned REG_WIDTH = 12;
    localparam int unsigned IM_WIDTH  = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        FLUSH   = 3'd2,
        RELEASE = 3'd3,
        START   = 3'd4
    } state_e;

endpackage

// File: rtl/ins_mem_loader_if.sv
// Host stream, Ins_Memory write port and CPU control signals of the loader.
interface ins_mem_loader_if
    import ins_mem_loader_pkg::*;
#(
    parameter int unsigned reg_width = REG_WIDTH,
    parameter int unsigned Im_width  = IM_WIDTH
);

    logic                 load_req;
    logic [Im_width:0]    load_len;
    logic                 in_valid;
    logic [reg_width-1:0] in_data;
    logic                 in_ready;
    logic [Im_width-1:0]  im_address;
    logic [reg_width-1:0] im_data;
    logic                 im_wren;
    logic                 cpu_reset;
    logic                 cpu_start;
    logic                 busy;
    logic                 done;
    logic [reg_width-1:0] checksum;

    modport slave (
        input  load_req, load_len, in_valid, in_data,
        output in_ready, im_address, im_data, im_wren,
        output cpu_reset, cpu_start, busy, done, checksum
    );

    modport master (
        output load_req, load_len, in_valid, in_data,
        input  in_ready, im_address, im_data, im_wren,
        input  cpu_reset, cpu_start, busy, done, checksum
    );

endinterface

// File: rtl/ins_mem_loader.sv
// Loads a stream of instruction words into Ins_Memory while holding the CPU in
// reset, then releases the CPU and pulses start so execution begins at PC 0.
module ins_mem_loader
    import ins_mem_loader_pkg::*;
#(
    parameter int unsigned reg_width = REG_WIDTH,
    parameter int unsigned Im_width  = IM_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    ins_mem_loader_if.slave   bus
);

    localparam logic [Im_width:0] MAX_LEN = {1'b1, {Im_width{1'b0}}};
    localparam logic [Im_width:0] LEN_ONE = (Im_width + 1)'(1);

    state_e               state_q, state_d;
    logic [Im_width:0]    len_q, len_d;
    logic [Im_width:0]    cnt_q, cnt_d;
    logic [Im_width-1:0]  addr_q, addr_d;
    logic [reg_width-1:0] data_q, data_d;
    logic [reg_width-1:0] sum_q, sum_d;
    logic                 wren_q, wren_d;
    logic                 cpu_rst_q, cpu_rst_d;
    logic                 start_q, start_d;
    logic                 done_q, done_d;
    logic                 xfer;

    assign xfer = (state_q == LOAD) && bus.in_valid;

    // State register and registered outputs; reset aborts any load in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            sum_q     <= '0;
            wren_q    <= 1'b0;
            cpu_rst_q <= 1'b1;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            sum_q     <= sum_d;
            wren_q    <= wren_d;
            cpu_rst_q <= cpu_rst_d;
            start_q   <= start_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic; each output register takes the value it must show in the next state.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        sum_d     = sum_q;
        wren_d    = 1'b0;
        cpu_rst_d = cpu_rst_q;
        start_d   = 1'b0;
        done_d    = done_q;
        case (state_q)
            IDLE: begin
                if (bus.load_req) begin
                    done_d = 1'b0;
                    if (bus.load_len != '0) begin
                        len_d     = (bus.load_len > MAX_LEN) ? MAX_LEN : bus.load_len;
                        cnt_d     = '0;
                        sum_d     = '0;
                        cpu_rst_d = 1'b1;
                        state_d   = LOAD;
                    end else begin
                        // Zero-length load just reruns the program already in memory.
                        cpu_rst_d = 1'b0;
                        state_d   = RELEASE;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    addr_d = cnt_q[Im_width-1:0];
                    data_d = bus.in_data;
                    wren_d = 1'b1;
                    sum_d  = sum_q + bus.in_data;
                    cnt_d  = cnt_q + LEN_ONE;
                    if (cnt_q == len_q - LEN_ONE) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                cpu_rst_d = 1'b0;
                state_d   = RELEASE;
            end
            RELEASE: begin
                start_d = 1'b1;
                state_d = START;
            end
            START: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready   = (state_q == LOAD);
    assign bus.busy       = (state_q != IDLE);
    assign bus.im_address = addr_q;
    assign bus.im_data    = data_q;
    assign bus.im_wren    = wren_q;
    assign bus.cpu_reset  = cpu_rst_q;
    assign bus.cpu_start  = start_q;
    assign bus.done       = done_q;
    assign bus.checksum   = sum_q;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Directed testbench for ins_mem_loader with hand-computed expectations.
module tb_ins_mem_loader;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    ins_mem_loader_if bus ();

    ins_mem_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.load_req = 1'b0;
        bus.load_len = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({bus.cpu_reset, bus.im_wren, bus.busy, bus.done, bus.in_ready, bus.cpu_start} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: got rst/wren/busy/done/rdy/start=%b exp 100000",
                     {bus.cpu_reset, bus.im_wren, bus.busy, bus.done, bus.in_ready, bus.cpu_start});
        end
        n_tests++;
        if ({bus.checksum, bus.im_address, bus.im_data} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_regs: got sum=%h addr=%h data=%h exp all 0",
                     bus.checksum, bus.im_address, bus.im_data);
        end
        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 12'hABC;
        tick();
        n_tests++;
        if ({bus.im_wren, bus.busy, bus.checksum} !== 14'h0 || bus.cpu_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_valid_ignored: got wren=%b busy=%b sum=%h rst=%b exp 0 0 000 1",
                     bus.im_wren, bus.busy, bus.checksum, bus.cpu_reset);
        end
        idle_inputs();
    endtask

    task automatic test_basic;
        logic [11:0] w [3] = '{12'h101, 12'h202, 12'h303};
        bus.load_req = 1'b1;
        bus.load_len = 9'd3;
        tick();
        bus.load_req = 1'b0;
        n_tests++;
        if ({bus.in_ready, bus.busy, bus.cpu_reset, bus.im_wren} !== 4'b1110) begin
            n_fail++;
            $display("FAIL basic_enter_load: got rdy/busy/rst/wren=%b exp 1110",
                     {bus.in_ready, bus.busy, bus.cpu_reset, bus.im_wren});
        end
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = w[i];
            tick();
            n_tests++;
            if ({bus.im_wren, bus.im_address, bus.im_data} !== {1'b1, 8'(i), w[i]}) begin
                n_fail++;
                $display("FAIL basic_write%0d: got wren=%b addr=%h data=%h exp 1 %h %h",
                         i, bus.im_wren, bus.im_address, bus.im_data, 8'(i), w[i]);
            end
        end
        bus.in_valid = 1'b0;
        n_tests++;
        if ({bus.in_ready, bus.cpu_reset} !== 2'b01) begin
            n_fail++;
            $display("FAIL basic_flush: got rdy=%b rst=%b exp 0 1", bus.in_ready, bus.cpu_reset);
        end
        tick();
        n_tests++;
        if ({bus.cpu_reset, bus.im_wren, bus.cpu_start} !== 3'b000) begin
            n_fail++;
            $display("FAIL basic_release: got rst/wren/start=%b exp 000",
                     {bus.cpu_reset, bus.im_wren, bus.cpu_start});
        end
        tick();
        n_tests++;
        if (bus.cpu_start !== 1'b1 || bus.checksum !== 12'h606) begin
            n_fail++;
            $display("FAIL basic_start: got start=%b sum=%h exp 1 606", bus.cpu_start, bus.checksum);
        end
        tick();
        n_tests++;
        if ({bus.cpu_start, bus.done, bus.busy, bus.cpu_reset} !== 4'b0100) begin
            n_fail++;
            $display("FAIL basic_done: got start/done/busy/rst=%b exp 0100",
                     {bus.cpu_start, bus.done, bus.busy, bus.cpu_reset});
        end
    endtask

    task automatic test_gaps;
        logic [6:0] pat = 7'b1010101;
        int unsigned nw = 0;
        bus.load_req = 1'b1;
        bus.load_len = 9'd4;
        tick();
        bus.load_req = 1'b0;
        n_tests++;
        if ({bus.done, bus.cpu_reset} !== 2'b01) begin
            n_fail++;
            $display("FAIL gaps_done_clear: got done=%b rst=%b exp 0 1", bus.done, bus.cpu_reset);
        end
        for (int k = 0; k < 7; k++) begin
            bus.in_valid = pat[k];
            bus.in_data  = pat[k] ? 12'(12'h040 + k) : 12'hFFF;
            tick();
            n_tests++;
            if (pat[k]) begin
                if ({bus.im_wren, bus.im_address, bus.im_data} !== {1'b1, 8'(nw), 12'(12'h040 + k)}) begin
                    n_fail++;
                    $display("FAIL gaps_write%0d: got wren=%b addr=%h data=%h exp 1 %h %h",
                             k, bus.im_wren, bus.im_address, bus.im_data, 8'(nw), 12'(12'h040 + k));
                end
                nw++;
            end else if (bus.im_wren !== 1'b0) begin
                n_fail++;
                $display("FAIL gaps_idle%0d: got wren=%b exp 0", k, bus.im_wren);
            end
            n_tests++;
            if (bus.in_ready !== (k < 6)) begin
                n_fail++;
                $display("FAIL gaps_ready%0d: got %b exp %b", k, bus.in_ready, (k < 6));
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 12'h7FF;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (bus.im_wren !== 1'b0 || bus.checksum !== 12'h10C) begin
                n_fail++;
                $display("FAIL gaps_post%0d: got wren=%b sum=%h exp 0 10c", k, bus.im_wren, bus.checksum);
            end
        end
        bus.in_valid = 1'b0;
        n_tests++;
        if ({bus.done, bus.busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL gaps_done: got done=%b busy=%b exp 1 0", bus.done, bus.busy);
        end
    endtask

    // Streams 256 words equal to their index; len is either exact or over-range.
    task automatic run_full(input logic [8:0] len, input string tag);
        bus.load_req = 1'b1;
        bus.load_len = len;
        tick();
        bus.load_req = 1'b0;
        for (int i = 0; i < 256; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 12'(i);
            tick();
            n_tests++;
            if ({bus.im_wren, bus.im_address, bus.im_data, bus.in_ready} !== {1'b1, 8'(i), 12'(i), (i < 255)}) begin
                n_fail++;
                $display("FAIL %s_write%0d: got wren=%b addr=%h data=%h rdy=%b exp 1 %h %h %b",
                         tag, i, bus.im_wren, bus.im_address, bus.im_data, bus.in_ready,
                         8'(i), 12'(i), (i < 255));
            end
        end
        bus.in_data = 12'h000;
        tick();
        n_tests++;
        if ({bus.im_wren, bus.cpu_reset} !== 2'b00 || bus.checksum !== 12'hF80) begin
            n_fail++;
            $display("FAIL %s_nowrap: got wren=%b rst=%b sum=%h exp 0 0 f80",
                     tag, bus.im_wren, bus.cpu_reset, bus.checksum);
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({bus.done, bus.busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s_done: got done=%b busy=%b exp 1 0", tag, bus.done, bus.busy);
        end
    endtask

    task automatic test_full;
        run_full(9'h100, "full");
    endtask

    task automatic test_clamp;
        run_full(9'h1FF, "clamp");
    endtask

    task automatic test_abort;
        bus.load_req = 1'b1;
        bus.load_len = 9'd5;
        tick();
        bus.load_req = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 12'h111;
        tick();
        bus.in_data  = 12'h222;
        tick();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        n_tests++;
        if ({bus.busy, bus.in_ready, bus.cpu_reset, bus.im_wren, bus.done} !== 5'b00100) begin
            n_fail++;
            $display("FAIL abort_state: got busy/rdy/rst/wren/done=%b exp 00100",
                     {bus.busy, bus.in_ready, bus.cpu_reset, bus.im_wren, bus.done});
        end
        n_tests++;
        if ({bus.checksum, bus.im_address} !== 20'h0) begin
            n_fail++;
            $display("FAIL abort_regs: got sum=%h addr=%h exp 000 00", bus.checksum, bus.im_address);
        end
        reset = 1'b1;
        tick();
        n_tests++;
        if ({bus.cpu_reset, bus.busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL abort_hold: got rst=%b busy=%b exp 1 0", bus.cpu_reset, bus.busy);
        end
        bus.load_req = 1'b1;
        bus.load_len = 9'd2;
        tick();
        bus.load_len = 9'd5;
        bus.in_valid = 1'b1;
        bus.in_data  = 12'h00A;
        tick();
        n_tests++;
        if ({bus.im_wren, bus.im_address, bus.im_data} !== {1'b1, 8'h00, 12'h00A}) begin
            n_fail++;
            $display("FAIL busyreq_w0: got wren=%b addr=%h data=%h exp 1 00 00a",
                     bus.im_wren, bus.im_address, bus.im_data);
        end
        bus.in_data = 12'h00B;
        tick();
        n_tests++;
        if ({bus.im_wren, bus.im_address, bus.im_data, bus.in_ready} !== {1'b1, 8'h01, 12'h00B, 1'b0}) begin
            n_fail++;
            $display("FAIL busyreq_w1: got wren=%b addr=%h data=%h rdy=%b exp 1 01 00b 0",
                     bus.im_wren, bus.im_address, bus.im_data, bus.in_ready);
        end
        bus.load_req = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        n_tests++;
        if ({bus.done, bus.busy, bus.checksum} !== {2'b10, 12'h015}) begin
            n_fail++;
            $display("FAIL busyreq_done: got done=%b busy=%b sum=%h exp 1 0 015",
                     bus.done, bus.busy, bus.checksum);
        end
    endtask

    task automatic test_zero;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_tests++;
        if (bus.cpu_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_pre: got rst=%b exp 1", bus.cpu_reset);
        end
        bus.load_req = 1'b1;
        bus.load_len = 9'd0;
        bus.in_valid = 1'b1;
        bus.in_data  = 12'h5A5;
        tick();
        bus.load_req = 1'b0;
        n_tests++;
        if ({bus.cpu_reset, bus.im_wren, bus.cpu_start, bus.busy, bus.in_ready, bus.done} !== 6'b000100) begin
            n_fail++;
            $display("FAIL zero_release: got rst/wren/start/busy/rdy/done=%b exp 000100",
                     {bus.cpu_reset, bus.im_wren, bus.cpu_start, bus.busy, bus.in_ready, bus.done});
        end
        tick();
        n_tests++;
        if ({bus.cpu_start, bus.im_wren, bus.cpu_reset} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_start: got start/wren/rst=%b exp 100",
                     {bus.cpu_start, bus.im_wren, bus.cpu_reset});
        end
        bus.in_valid = 1'b0;
        tick();
        n_tests++;
        if ({bus.cpu_start, bus.done, bus.busy, bus.im_wren} !== 4'b0100 || bus.checksum !== 12'h000) begin
            n_fail++;
            $display("FAIL zero_done: got start/done/busy/wren=%b sum=%h exp 0100 000",
                     {bus.cpu_start, bus.done, bus.busy, bus.im_wren}, bus.checksum);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_full();
        test_clamp();
        test_abort();
        test_zero();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
